gfx_pattern_gen: RTL

Parametrised, multi-mode successor to the single-pattern demo source. Streams one frame of framebuffer pixels (x, y, color) over a valid/ready handshake, in raster order. Selectable patterns: solid, vertical bars, horizontal bars, checkerboard, gradient. Feeds the framebuffer writer and VGA test paths, and runs one-shot or continuously.

---
 rtl/gfx_pattern_gen_pkg.sv | 17 +
 rtl/gfx_pattern_gen_if.sv | 20 ++
 rtl/gfx_pattern_gen_color.sv | 40 ++++
 rtl/gfx_pattern_gen.sv | 124 ++++++++++++
 4 files changed

// File: rtl/gfx_pattern_gen_pkg.sv
// gfx_pattern_gen_pkg: pattern mode codes, FSM states and sizing helpers for the pattern generator.
package gfx_pattern_gen_pkg;

    localparam logic [2:0] GFX_PAT_SOLID = 3'd0;
    localparam logic [2:0] GFX_PAT_VBARS = 3'd1;
    localparam logic [2:0] GFX_PAT_HBARS = 3'd2;
    localparam logic [2:0] GFX_PAT_CHECK = 3'd3;
    localparam logic [2:0] GFX_PAT_GRAD  = 3'd4;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    // Tiny frames would give a zero bar size; clamp so every line/row still advances the bar
    function automatic int bar_size(input int n);
        return (n / 8 > 0) ? n / 8 : 1;
    endfunction

endpackage

// File: rtl/gfx_pattern_gen_if.sv
// gfx_pattern_gen_if: valid/ready pixel stream carrying x, y, color and end-of-frame marker.
interface gfx_pattern_gen_if #(
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int COLOR_BITS = 12
);
    localparam int FB_X_BITS = $clog2(FB_WIDTH);
    localparam int FB_Y_BITS = $clog2(FB_HEIGHT);

    logic                  valid;
    logic                  ready;
    logic [FB_X_BITS-1:0]  x;
    logic [FB_Y_BITS-1:0]  y;
    logic [COLOR_BITS-1:0] color;
    logic                  last;

    modport master (output valid, x, y, color, last, input ready);
    modport slave  (input valid, x, y, color, last, output ready);

endinterface

// File: rtl/gfx_pattern_gen_color.sv
// gfx_pattern_color: combinational pixel color for a given mode, coordinate and bar indices.
module gfx_pattern_color
    import gfx_pattern_gen_pkg::*;
#(
    parameter int COLOR_BITS  = 12,
    parameter int CHECK_SHIFT = 5,
    parameter int X_BITS      = 10,
    parameter int Y_BITS      = 9
) (
    input  logic [2:0]            mode,
    input  logic [X_BITS-1:0]     x,
    input  logic [Y_BITS-1:0]     y,
    input  logic [2:0]            vbar,
    input  logic [2:0]            hbar,
    input  logic [COLOR_BITS-1:0] solid_color,
    output logic [COLOR_BITS-1:0] color
);
    localparam int CB = COLOR_BITS / 3;

    // Zero-pad below the coordinate so the top CB bits exist even when the coordinate is narrower
    logic [X_BITS+CB-1:0] xw;
    logic [Y_BITS+CB-1:0] yw;
    logic                 unused_bits;

    assign xw = {x, {CB{1'b0}}};
    assign yw = {y, {CB{1'b0}}};
    assign unused_bits = ^{xw, yw};

    function automatic logic [COLOR_BITS-1:0] bar_rgb(input logic [2:0] i);
        return {{CB{i[2]}}, {CB{i[1]}}, {CB{i[0]}}};
    endfunction

    always_comb
        color = (mode == GFX_PAT_VBARS) ? bar_rgb(vbar) :
                (mode == GFX_PAT_HBARS) ? bar_rgb(hbar) :
                (mode == GFX_PAT_CHECK) ? {COLOR_BITS{x[CHECK_SHIFT] ^ y[CHECK_SHIFT]}} :
                (mode == GFX_PAT_GRAD)  ? {xw[X_BITS+CB-1 -: CB], yw[Y_BITS+CB-1 -: CB], {CB{1'b0}}} :
                                          solid_color;

endmodule

// File: rtl/gfx_pattern_gen.sv
// gfx_pattern_gen: streams one frame (or frames back to back) of pattern pixels in raster order.
module gfx_pattern_gen
    import gfx_pattern_gen_pkg::*;
#(
    parameter int FB_WIDTH    = 640,
    parameter int FB_HEIGHT   = 480,
    parameter int COLOR_BITS  = 12,
    parameter int CHECK_SHIFT = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [2:0]            mode,
    input  logic [COLOR_BITS-1:0] solid_color,
    gfx_pattern_gen_if.master     pix,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int XB = $clog2(FB_WIDTH);
    localparam int YB = $clog2(FB_HEIGHT);
    localparam logic [XB-1:0] X_MAX  = XB'(FB_WIDTH - 1);
    localparam logic [YB-1:0] Y_MAX  = YB'(FB_HEIGHT - 1);
    localparam logic [XB-1:0] BW_MAX = XB'(bar_size(FB_WIDTH) - 1);
    localparam logic [YB-1:0] BH_MAX = YB'(bar_size(FB_HEIGHT) - 1);

    state_t                state, state_nx;
    logic [2:0]            mode_q, mode_s;
    logic [COLOR_BITS-1:0] solid_q, solid_s, color_nx;
    logic [XB-1:0]         vcnt, vcnt_nx, x_nx;
    logic [YB-1:0]         hcnt, hcnt_nx, y_nx;
    logic [2:0]            vbar, vbar_nx, hbar, hbar_nx;
    logic                  hs, fin, restart, load, last_nx;

    assign pix.valid = state == ST_RUN;
    assign busy      = pix.valid;
    assign hs        = pix.valid && pix.ready;
    assign fin       = hs && pix.last;
    assign restart   = (state == ST_IDLE && start) || (fin && continuous);
    assign load      = restart || hs;
    assign mode_s    = restart ? mode : mode_q;
    assign solid_s   = restart ? solid_color : solid_q;

    always_comb
        state_nx = (state == ST_IDLE) ? (start ? ST_RUN : ST_IDLE) :
                   (fin && !continuous) ? ST_IDLE : ST_RUN;

    // Bar indices are tracked with small run-length counters instead of dividing x or y
    always_comb begin
        x_nx    = pix.x + 1'b1;
        y_nx    = pix.y;
        vcnt_nx = (vcnt == BW_MAX) ? '0 : vcnt + 1'b1;
        vbar_nx = (vcnt == BW_MAX && vbar != 3'd7) ? vbar + 3'd1 : vbar;
        hcnt_nx = hcnt;
        hbar_nx = hbar;
        if (pix.x == X_MAX) begin
            x_nx    = '0;
            y_nx    = pix.y + 1'b1;
            vcnt_nx = '0;
            vbar_nx = '0;
            hcnt_nx = (hcnt == BH_MAX) ? '0 : hcnt + 1'b1;
            hbar_nx = (hcnt == BH_MAX && hbar != 3'd7) ? hbar + 3'd1 : hbar;
        end
        if (restart || fin) begin
            x_nx    = '0;
            y_nx    = '0;
            vcnt_nx = '0;
            vbar_nx = '0;
            hcnt_nx = '0;
            hbar_nx = '0;
        end
        last_nx = x_nx == X_MAX && y_nx == Y_MAX;
    end

    gfx_pattern_color #(
        .COLOR_BITS (COLOR_BITS),
        .CHECK_SHIFT(CHECK_SHIFT),
        .X_BITS     (XB),
        .Y_BITS     (YB)
    ) u_color (
        .mode       (mode_s),
        .x          (x_nx),
        .y          (y_nx),
        .vbar       (vbar_nx),
        .hbar       (hbar_nx),
        .solid_color(solid_s),
        .color      (color_nx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            frame_done <= 1'b0;
            mode_q     <= GFX_PAT_SOLID;
            solid_q    <= '0;
            vcnt       <= '0;
            vbar       <= '0;
            hcnt       <= '0;
            hbar       <= '0;
            pix.x      <= '0;
            pix.y      <= '0;
            pix.color  <= '0;
            pix.last   <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_done <= fin;
            if (restart) begin
                mode_q  <= mode;
                solid_q <= solid_color;
            end
            if (load) begin
                vcnt      <= vcnt_nx;
                vbar      <= vbar_nx;
                hcnt      <= hcnt_nx;
                hbar      <= hbar_nx;
                pix.x     <= x_nx;
                pix.y     <= y_nx;
                pix.color <= color_nx;
                pix.last  <= last_nx;
            end
        end
    end

endmodule
